// File: rtl/bist_pkg.sv
// bist_pkg: shared widths and the background-pattern helper for the BIST datapath.
package bist_pkg;
   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;
   localparam int ERR_W = 16;
   localparam int MAX_DATA_W = 64;
   function automatic logic [MAX_DATA_W-1:0] bg_pattern(input logic b);
      return {MAX_DATA_W{b}};
   endfunction
endpackage

// File: rtl/bist_addr_counter.sv
// bist_addr_counter: prioritized up/down address counter with terminal-count carry.
module bist_addr_counter #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reset,
   input  logic              preset,
   input  logic              en,
   input  logic              up_down,
   output logic [ADDR_W-1:0] cnt,
   output logic              carry
);
   always_ff @(posedge clk)
      if (rst || reset) cnt <= '0;
      else if (preset) cnt <= '1;
      else if (en) cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
   assign carry = up_down ? &cnt : ~|cnt;
endmodule

// File: rtl/bist_datapath.sv
// bist_datapath: BIST address counter, memory strobes and read-compare pipeline; BIST_DATAPATH_ERRLOG_EN adds the error log.
module bist_datapath import bist_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reset,
   input  logic              preset,
   input  logic              en,
   input  logic              up_down,
   input  logic              wr,
   input  logic              out,
   output logic              carry,
   output logic              is_equal,
   output logic              cmp_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef BIST_DATAPATH_ERRLOG_EN
   ,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic              fail_seen
`endif
);
   logic acc, pend, exp_q, match;
   bist_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
      .clk(clk), .rst(rst), .reset(reset), .preset(preset), .en(en),
      .up_down(up_down), .cnt(mem_addr), .carry(carry)
   );
   assign acc = en & ~reset & ~preset & ~rst;
   assign mem_we = acc & wr;
   assign mem_re = acc & ~wr;
   assign mem_wdata = DATA_W'(bg_pattern(out));
   assign match = mem_rdata == DATA_W'(bg_pattern(exp_q));
   always_ff @(posedge clk)
      if (rst) begin
         pend <= 1'b0;
         cmp_valid <= 1'b0;
         is_equal <= 1'b1;
         exp_q <= 1'b0;
      end else begin
         pend <= mem_re;
         cmp_valid <= pend;
         if (mem_re) exp_q <= out;
         if (pend) is_equal <= match;
      end
`ifdef BIST_DATAPATH_ERRLOG_EN
   logic [ADDR_W-1:0] addr_q;
   always_ff @(posedge clk)
      if (rst) begin
         addr_q <= '0;
         err_cnt <= '0;
         fail_addr <= '0;
         fail_seen <= 1'b0;
      end else begin
         if (mem_re) addr_q <= mem_addr;
         if (pend && !match) begin
            if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
            if (!fail_seen) begin
               fail_addr <= addr_q;
               fail_seen <= 1'b1;
            end
         end
      end
`endif
endmodule

// File: tb/tb_bist_datapath.sv
// tb_bist_datapath: randomized self-checking bench for bist_datapath against a cycle-level reference model.
module tb_bist_datapath;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int TOP = (1 << AW) - 1;
   logic clk = 1'b0;
   logic rst, reset, preset, en, up_down, wr, out;
   logic carry, is_equal, cmp_valid, mem_we, mem_re;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef BIST_DATAPATH_ERRLOG_EN
   logic [15:0] err_cnt;
   logic [AW-1:0] fail_addr;
   logic fail_seen;
`endif
   bist_datapath #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .reset(reset), .preset(preset), .en(en),
      .up_down(up_down), .wr(wr), .out(out), .carry(carry),
      .is_equal(is_equal), .cmp_valid(cmp_valid), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
`ifdef BIST_DATAPATH_ERRLOG_EN
      , .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_seen(fail_seen)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {int due; logic eq; int addr;} res_t;
   res_t q[$];
   logic [DW-1:0] mem [TOP+1];
   int total = 0, bad = 0, cyc = 0;
   int m_cnt = 0, m_err = 0, m_fa = 0;
   logic m_ieq = 1'b1, m_fs = 1'b0;
   int n_cmp = 0, n_miss = 0, miss_idx = 0;
   task automatic step(input logic rs, r, p, e, ud, w, o);
      logic a, dre, dwe;
      logic [AW-1:0] da;
      logic [DW-1:0] dwd;
      rst = rs; reset = r; preset = p; en = e; up_down = ud; wr = w; out = o;
      @(negedge clk);
      a = e && !r && !p && !rs;
      total++; if (mem_addr !== AW'(m_cnt)) begin bad++; $display("FAIL mem_addr cyc=%0d got %0d want %0d", cyc, mem_addr, m_cnt); end
      total++; if (mem_we !== (a && w)) begin bad++; $display("FAIL mem_we cyc=%0d got %b want %b", cyc, mem_we, a && w); end
      total++; if (mem_re !== (a && !w)) begin bad++; $display("FAIL mem_re cyc=%0d got %b want %b", cyc, mem_re, a && !w); end
      total++; if (carry !== (ud ? m_cnt == TOP : m_cnt == 0)) begin bad++; $display("FAIL carry cyc=%0d got %b cnt=%0d ud=%b", cyc, carry, m_cnt, ud); end
      if (a && w) begin
         total++; if (mem_wdata !== {DW{o}}) begin bad++; $display("FAIL mem_wdata cyc=%0d got %h want %h", cyc, mem_wdata, {DW{o}}); end
      end
      if (q.size() > 0 && q[0].due == cyc) begin
         total++; if (cmp_valid !== 1'b1) begin bad++; $display("FAIL cmp_valid cyc=%0d got %b want 1", cyc, cmp_valid); end
         total++; if (is_equal !== q[0].eq) begin bad++; $display("FAIL is_equal cyc=%0d got %b want %b", cyc, is_equal, q[0].eq); end
         m_ieq = q[0].eq;
         if (!q[0].eq) begin
            m_err++;
            if (!m_fs) begin m_fs = 1'b1; m_fa = q[0].addr; end
         end
         void'(q.pop_front());
      end else begin
         total++; if (cmp_valid !== 1'b0) begin bad++; $display("FAIL cmp_valid idle cyc=%0d got %b want 0", cyc, cmp_valid); end
         total++; if (is_equal !== m_ieq) begin bad++; $display("FAIL is_equal hold cyc=%0d got %b want %b", cyc, is_equal, m_ieq); end
      end
      if (cmp_valid === 1'b1) begin
         n_cmp++;
         if (is_equal === 1'b0) begin n_miss++; miss_idx = n_cmp; end
      end
`ifdef BIST_DATAPATH_ERRLOG_EN
      total++; if (err_cnt !== 16'(m_err)) begin bad++; $display("FAIL err_cnt cyc=%0d got %0d want %0d", cyc, err_cnt, m_err); end
      total++; if (fail_seen !== m_fs) begin bad++; $display("FAIL fail_seen cyc=%0d got %b want %b", cyc, fail_seen, m_fs); end
      if (m_fs) begin
         total++; if (fail_addr !== AW'(m_fa)) begin bad++; $display("FAIL fail_addr cyc=%0d got %0d want %0d", cyc, fail_addr, m_fa); end
      end
`endif
      if (a && !w) q.push_back('{cyc + 2, mem[m_cnt] == {DW{o}}, m_cnt});
      dre = mem_re; dwe = mem_we; da = mem_addr; dwd = mem_wdata;
      if (rs) begin
         m_cnt = 0; q.delete(); m_ieq = 1'b1; m_err = 0; m_fs = 1'b0; m_fa = 0;
      end else if (r) m_cnt = 0;
      else if (p) m_cnt = TOP;
      else if (e) m_cnt = ud ? (m_cnt + 1) % (TOP + 1) : (m_cnt + TOP) % (TOP + 1);
      @(posedge clk); #1; cyc++;
      mem_rdata = dre ? mem[da] : DW'($urandom);
      if (dwe) mem[da] = dwd;
   endtask
   task automatic test_reset();
      rst = 1'b1; reset = 1'b0; preset = 1'b0; en = 1'b0; up_down = 1'b0; wr = 1'b0; out = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_cnt = 0; q.delete(); m_ieq = 1'b1; m_err = 0; m_fs = 1'b0; m_fa = 0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic test_write_down();
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i <= TOP; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic test_read_up();
      int base;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      base = n_cmp;
      for (int i = 0; i <= TOP; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (n_cmp - base !== TOP + 1) begin bad++; $display("FAIL read_sweep_pulses got %0d want %0d", n_cmp - base, TOP + 1); end
   endtask
   task automatic test_corrupt();
      int base, miss0;
      mem[5] = 8'h10;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      base = n_cmp; miss0 = n_miss;
      for (int i = 0; i <= TOP; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      total++; if (n_miss - miss0 !== 1) begin bad++; $display("FAIL corrupt_miss_count got %0d want 1", n_miss - miss0); end
      total++; if (miss_idx - base !== 6) begin bad++; $display("FAIL corrupt_miss_pos got %0d want 6", miss_idx - base); end
`ifdef BIST_DATAPATH_ERRLOG_EN
      total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL corrupt_err_cnt got %0d want 1", err_cnt); end
      total++; if (fail_addr !== AW'(5)) begin bad++; $display("FAIL corrupt_fail_addr got %0d want 5", fail_addr); end
`endif
      mem[5] = 8'h00;
   endtask
   task automatic test_priority();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (7) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      total++; if (mem_addr !== AW'(7)) begin bad++; $display("FAIL prio_setup got %0d want 7", mem_addr); end
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask
   task automatic test_rst_mid();
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_mid_addr got %0d want 0", mem_addr); end
   endtask
   task automatic test_random();
      for (int i = 0; i < 500; i++)
         step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0,
              $urandom_range(3) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask
   initial begin
      for (int i = 0; i <= TOP; i++) mem[i] = '0;
      mem_rdata = '0;
      test_reset();
      test_write_down();
      test_read_up();
      test_corrupt();
      test_priority();
      test_rst_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
